// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the multicycle controller.
// Holds RV32I opcode values, the R-type and I-type ALUop tables, the FSM
// state enum, the instruction class used to sequence EXEC/MEM/WB, the
// wb_sel/pc_sel encodings and the registered control bundle.
package ctrl_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // R-type ALUop table
    localparam logic [3:0] ALU_R_ADD  = 4'b0000;
    localparam logic [3:0] ALU_R_SUB  = 4'b0001;
    localparam logic [3:0] ALU_R_XOR  = 4'b0010;
    localparam logic [3:0] ALU_R_OR   = 4'b0011;
    localparam logic [3:0] ALU_R_AND  = 4'b0100;
    localparam logic [3:0] ALU_R_SLL  = 4'b0101;
    localparam logic [3:0] ALU_R_SRL  = 4'b0110;
    localparam logic [3:0] ALU_R_SRA  = 4'b0111;
    localparam logic [3:0] ALU_R_SLT  = 4'b1000;
    localparam logic [3:0] ALU_R_SLTU = 4'b1001;

    // I-type ALUop table (the ALU numbers these differently from R-type)
    localparam logic [3:0] ALU_I_ADDI = 4'b0000;
    localparam logic [3:0] ALU_I_XORI = 4'b0001;
    localparam logic [3:0] ALU_I_ORI  = 4'b0010;
    localparam logic [3:0] ALU_I_ANDI = 4'b0011;
    localparam logic [3:0] ALU_I_SLLI = 4'b0100;
    localparam logic [3:0] ALU_I_SRAI = 4'b0101;
    localparam logic [3:0] ALU_I_SRLI = 4'b0110;

    localparam logic [3:0] ALU_LUI    = 4'b1000;
    localparam logic [3:0] ALU_AUIPC  = 4'b1001;

    // wb_sel / pc_sel encodings
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,   // R, I-ALU, lui, auipc
        CL_BRANCH = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_JAL    = 3'd4,
        CL_JALR   = 3'd5
    } class_e;

    // br bit order: [5] beq, [4] bne, [3] blt, [2] bge, [1] bltu, [0] bgeu
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       sftmd;
        logic [5:0] br;
        class_e     cls;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational decode of an RV32I instruction into
// the controller's control bundle.
// Ports: opcode/funct3/funct7 in (instruction fields), ctrl out (bundle),
// illegal out (instruction not supported by this datapath).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        ctrl.cls = CL_ALU;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: ctrl.alu_op = ALU_R_ADD;
                        3'b001: begin ctrl.alu_op = ALU_R_SLL; ctrl.sftmd = 1'b1; end
                        3'b010: ctrl.alu_op = ALU_R_SLT;
                        3'b011: ctrl.alu_op = ALU_R_SLTU;
                        3'b100: ctrl.alu_op = ALU_R_XOR;
                        3'b101: begin ctrl.alu_op = ALU_R_SRL; ctrl.sftmd = 1'b1; end
                        3'b110: ctrl.alu_op = ALU_R_OR;
                        default: ctrl.alu_op = ALU_R_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  ctrl.alu_op = ALU_R_SUB;
                        3'b101:  begin ctrl.alu_op = ALU_R_SRA; ctrl.sftmd = 1'b1; end
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                ctrl.alu_src = 1'b1;
                case (funct3)
                    3'b000: ctrl.alu_op = ALU_I_ADDI;
                    3'b100: ctrl.alu_op = ALU_I_XORI;
                    3'b110: ctrl.alu_op = ALU_I_ORI;
                    3'b111: ctrl.alu_op = ALU_I_ANDI;
                    3'b001: begin
                        ctrl.alu_op = ALU_I_SLLI;
                        ctrl.sftmd  = 1'b1;
                        illegal     = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        ctrl.sftmd = 1'b1;
                        if (funct7 == 7'b0000000)      ctrl.alu_op = ALU_I_SRLI;
                        else if (funct7 == 7'b0100000) ctrl.alu_op = ALU_I_SRAI;
                        else                           illegal = 1'b1;
                    end
                    default: illegal = 1'b1;   // slti / sltiu unsupported
                endcase
            end
            OP_LOAD: begin
                ctrl.alu_src = 1'b1;
                ctrl.cls     = CL_LOAD;
            end
            OP_STORE: begin
                ctrl.alu_src = 1'b1;
                ctrl.cls     = CL_STORE;
            end
            OP_JALR: begin
                ctrl.alu_src = 1'b1;
                ctrl.cls     = CL_JALR;
                illegal      = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl.alu_op  = ALU_LUI;
                ctrl.alu_src = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.alu_op  = ALU_AUIPC;
                ctrl.alu_src = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.cls = CL_BRANCH;
                case (funct3)
                    3'b000:  ctrl.br = 6'b100000;
                    3'b001:  ctrl.br = 6'b010000;
                    3'b100:  ctrl.br = 6'b001000;
                    3'b101:  ctrl.br = 6'b000100;
                    3'b110:  ctrl.br = 6'b000010;
                    3'b111:  ctrl.br = 6'b000001;
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl.cls = CL_JAL;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM (IDLE, FETCH, DECODE, EXEC,
// MEM, WB, TRAP) driving the ALU control interface, memory strobes,
// register-file write and PC update.
// Ports: clk, rst_n (async active-low); instruction handshake instr_valid/
// instr/instr_ready; mem_ready; branch_result; ALU controls ALUop/ALUSrc/
// sftmd and one-hot branch flags; MemRead/MemWrite; RegWrite; wb_sel;
// pc_we/pc_sel; ir (latched instruction); trap (sticky illegal flag).
// Optional macro CTRL_RETIRE_CNT_EN adds retired_cnt, a wrapping count of
// pc_we pulses.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        mem_ready,
    input  logic        branch_result,
    output logic [3:0]  ALUop,
    output logic        ALUSrc,
    output logic        sftmd,
    output logic        Branch,
    output logic        nBranch,
    output logic        Branch_lt,
    output logic        Branch_ge,
    output logic        Branch_ltu,
    output logic        Branch_geu,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [31:0] ir,
    output logic        trap
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    ctrl_t       dec_ctrl;
    logic        dec_illegal;

    ctrl_decode u_decode (
        .opcode  (ir_q[6:0]),
        .funct3  (ir_q[14:12]),
        .funct7  (ir_q[31:25]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Next state plus the two registered payloads (ir, control bundle).
    // The bundle only loads on DECODE->EXEC so the ALU sees stable controls
    // for the whole execute/memory/writeback sequence.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                end else begin
                    ctrl_d  = dec_ctrl;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (ctrl_q.cls)
                    CL_BRANCH:         state_d = ST_FETCH;
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready)
                    state_d = (ctrl_q.cls == CL_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the current state so an asynchronous reset
    // clears them in the same cycle it is asserted.
    always_comb begin
        instr_ready = (state_q == ST_FETCH);
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        wb_sel      = WB_ALU;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        trap        = (state_q == ST_TRAP);
        case (state_q)
            ST_IDLE: pc_sel = RESET_PC_SEL;
            ST_EXEC: begin
                if (ctrl_q.cls == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_result ? PC_IMM : PC_PLUS4;
                end
            end
            ST_MEM: begin
                MemRead  = (ctrl_q.cls == CL_LOAD);
                MemWrite = (ctrl_q.cls == CL_STORE);
                pc_we    = mem_ready && (ctrl_q.cls == CL_STORE);
            end
            ST_WB: begin
                RegWrite = 1'b1;
                pc_we    = 1'b1;
                case (ctrl_q.cls)
                    CL_LOAD: wb_sel = WB_MEM;
                    CL_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_IMM; end
                    CL_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU; end
                    default: wb_sel = WB_ALU;
                endcase
            end
            default: ;
        endcase
    end

    // In TRAP the bundle still holds the last legal instruction; blank it
    // (and ir) so only trap is visible.
    always_comb begin
        if (state_q == ST_TRAP) begin
            {ALUop, ALUSrc, sftmd} = '0;
            {Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu} = '0;
            ir = '0;
        end else begin
            ALUop  = ctrl_q.alu_op;
            ALUSrc = ctrl_q.alu_src;
            sftmd  = ctrl_q.sftmd;
            {Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu} = ctrl_q.br;
            ir = ir_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Wraps naturally at 32 bits.
    always_comb begin
        retired_d = retired_q + {31'd0, pc_we};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven bench for multicycle_ctrl plus directed
// sequences for reset release, illegal-instruction trap and reset mid-MEM.
module tb_multicycle_ctrl;

    localparam logic [1:0] RST_SEL = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic        mem_ready = 1'b0;
    logic        branch_result = 1'b0;
    logic [3:0]  ALUop;
    logic        ALUSrc, sftmd;
    logic        Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu;
    logic        MemRead, MemWrite, RegWrite, pc_we, trap;
    logic [1:0]  wb_sel, pc_sel;
    logic [31:0] ir;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    multicycle_ctrl #(.RESET_PC_SEL(RST_SEL)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_ready(mem_ready),
        .branch_result(branch_result), .ALUop(ALUop), .ALUSrc(ALUSrc),
        .sftmd(sftmd), .Branch(Branch), .nBranch(nBranch),
        .Branch_lt(Branch_lt), .Branch_ge(Branch_ge),
        .Branch_ltu(Branch_ltu), .Branch_geu(Branch_geu),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .ir(ir), .trap(trap)
`ifdef CTRL_RETIRE_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          wait_cyc;   // MEM cycles before mem_ready
        logic        br;
        logic [3:0]  aluop;
        logic        alusrc;
        logic        sft;
        logic [5:0]  flags;      // {beq,bne,blt,bge,bltu,bgeu}
        int          lat;        // handshake..pc_we inclusive
        logic [1:0]  pcsel;
        int          rw;
        logic [1:0]  wbsel;
        int          mr;
        int          mw;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retired = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_retired(input string name);
`ifdef CTRL_RETIRE_CNT_EN
        chk({name, " retired_cnt"}, retired_cnt, exp_retired);
`endif
    endtask

    function automatic logic [5:0] flags_now();
        return {Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu};
    endfunction

    // Everything except pc_sel and ir, in one word.
    function automatic logic [31:0] misc_outs();
        return {14'd0, instr_ready, ALUop, ALUSrc, sftmd, flags_now(),
                MemRead, MemWrite, RegWrite, wb_sel, pc_we, trap};
    endfunction

    task automatic wait_fetch(input string name);
        int n = 0;
        #1;
        while (!instr_ready && n < 10) begin
            @(negedge clk); #1; n++;
        end
        if (!instr_ready) chk({name, " fetch timeout"}, 32'd0, 32'd1);
    endtask

    // Release reset at a negedge: one IDLE cycle, then FETCH.
    task automatic release_reset(input string name);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({name, " idle instr_ready"}, {31'd0, instr_ready}, 32'd0);
        chk({name, " idle pc_sel"}, {30'd0, pc_sel}, {30'd0, RST_SEL});
        @(negedge clk); #1;
        chk({name, " fetch instr_ready"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 1, lat = 0, rw = 0, mr = 0, mw = 0, pw = 0, memcyc = 0;
        logic [1:0] psel = 2'd0, wsel = 2'd0;
        logic [3:0] aop = '0;
        logic asrc = 1'b0, sft = 1'b0, irdy = 1'b0;
        logic [5:0] fl = '0;
        logic [31:0] ir_seen = '0;
        bit done = 0;
        wait_fetch(v.name);
        branch_result = v.br;
        instr = v.instr;
        instr_valid = 1'b1;
        @(negedge clk);
        instr = 32'hFFFF_FFFF;   // valid stays high: must be ignored
        while (!done && cyc < 30) begin
            if (MemRead || MemWrite) begin
                memcyc++;
                mem_ready = (memcyc == v.wait_cyc + 1);
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (instr_ready) irdy = 1'b1;
            if (cyc == 2) begin
                aop = ALUop; asrc = ALUSrc; sft = sftmd; fl = flags_now(); ir_seen = ir;
            end
            if (RegWrite) begin rw++; wsel = wb_sel; end
            if (MemRead) mr++;
            if (MemWrite) mw++;
            if (pc_we) begin
                pw++; psel = pc_sel; lat = cyc + 1; done = 1;
                instr_valid = 1'b0;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            cyc++;
        end
        if (!done) chk({v.name, " pc_we timeout"}, 32'd0, 32'd1);
        exp_retired++;
        #1;
        $display("txn %s: instr=%08h ALUop=%b src=%b sft=%b flags=%b lat=%0d pc_sel=%0d RegWrite=%0d wb_sel=%0d MemRead=%0d MemWrite=%0d",
                 v.name, v.instr, aop, asrc, sft, fl, lat, psel, rw, wsel, mr, mw);
        chk({v.name, " ir"}, ir_seen, v.instr);
        chk({v.name, " ALUop"}, {28'd0, aop}, {28'd0, v.aluop});
        chk({v.name, " ALUSrc"}, {31'd0, asrc}, {31'd0, v.alusrc});
        chk({v.name, " sftmd"}, {31'd0, sft}, {31'd0, v.sft});
        chk({v.name, " branch flags"}, {26'd0, fl}, {26'd0, v.flags});
        chk({v.name, " latency"}, lat, v.lat);
        chk({v.name, " pc_we pulses"}, pw, 1);
        chk({v.name, " pc_sel"}, {30'd0, psel}, {30'd0, v.pcsel});
        chk({v.name, " RegWrite pulses"}, rw, v.rw);
        chk({v.name, " wb_sel"}, {30'd0, wsel}, {30'd0, v.wbsel});
        chk({v.name, " MemRead cycles"}, mr, v.mr);
        chk({v.name, " MemWrite cycles"}, mw, v.mw);
        chk({v.name, " instr_ready outside FETCH"}, {31'd0, irdy}, 32'd0);
        chk({v.name, " back in FETCH"}, {31'd0, instr_ready}, 32'd1);
        chk_retired(v.name);
    endtask

    task automatic run_trap(input string name, input logic [31:0] word);
        logic t2 = 1'b0, bad = 1'b0;
        logic [31:0] leak = '0;
        wait_fetch(name);
        instr = word;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            #1;
            if (c == 2) t2 = trap;
            if (c >= 2 && !trap) bad = 1'b1;
            if (pc_we || RegWrite || instr_ready) bad = 1'b1;
            if (c >= 2) leak = leak | (misc_outs() & ~32'd1) | {30'd0, pc_sel} | ir;
            @(negedge clk);
        end
        $display("txn %s: instr=%08h trap@2=%b stray=%b leak=%0h", name, word, t2, bad, leak);
        chk({name, " trap after DECODE"}, {31'd0, t2}, 32'd1);
        chk({name, " no pulses/ready, trap sticky"}, {31'd0, bad}, 32'd0);
        chk({name, " other outputs zero in TRAP"}, leak, 32'd0);
        chk_retired(name);
        rst_n = 1'b0;
        exp_retired = 0;
        release_reset({name, " reset"});
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{"add",        32'h002081B3, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[1]  = '{"sub",        32'h402081B3, 0, 1'b0, 4'b0001, 1'b0, 1'b0, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[2]  = '{"sra",        32'h4020D1B3, 0, 1'b0, 4'b0111, 1'b0, 1'b1, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[3]  = '{"sltu",       32'h0020B1B3, 0, 1'b0, 4'b1001, 1'b0, 1'b0, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[4]  = '{"srai",       32'h4030D093, 0, 1'b0, 4'b0101, 1'b1, 1'b1, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[5]  = '{"andi",       32'h0050F093, 0, 1'b0, 4'b0011, 1'b1, 1'b0, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[6]  = '{"lw wait3",   32'h0000A283, 3, 1'b0, 4'b0000, 1'b1, 1'b0, 6'b000000, 8, 2'd0, 1, 2'd1, 4, 0};
        vecs[7]  = '{"sw wait0",   32'h0020A223, 0, 1'b0, 4'b0000, 1'b1, 1'b0, 6'b000000, 4, 2'd0, 0, 2'd0, 0, 1};
        vecs[8]  = '{"lw wait0",   32'h0000A283, 0, 1'b0, 4'b0000, 1'b1, 1'b0, 6'b000000, 5, 2'd0, 1, 2'd1, 1, 0};
        vecs[9]  = '{"beq taken",  32'h00208463, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 6'b100000, 3, 2'd1, 0, 2'd0, 0, 0};
        vecs[10] = '{"beq fall",   32'h00208463, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'b100000, 3, 2'd0, 0, 2'd0, 0, 0};
        vecs[11] = '{"bgeu taken", 32'h0020F463, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 6'b000001, 3, 2'd1, 0, 2'd0, 0, 0};
        vecs[12] = '{"bne fall",   32'h00209463, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'b010000, 3, 2'd0, 0, 2'd0, 0, 0};
        vecs[13] = '{"jal",        32'h008000EF, 0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'b000000, 4, 2'd1, 1, 2'd2, 0, 0};
        vecs[14] = '{"jalr",       32'h000100E7, 0, 1'b0, 4'b0000, 1'b1, 1'b0, 6'b000000, 4, 2'd2, 1, 2'd2, 0, 0};
        vecs[15] = '{"lui",        32'h123450B7, 0, 1'b0, 4'b1000, 1'b1, 1'b0, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};
        vecs[16] = '{"auipc",      32'h00000097, 0, 1'b0, 4'b1001, 1'b1, 1'b0, 6'b000000, 4, 2'd0, 1, 2'd0, 0, 0};

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset outputs", misc_outs(), 32'd0);
        chk("reset pc_sel", {30'd0, pc_sel}, {30'd0, RST_SEL});
        chk("reset ir", ir, 32'd0);
        chk_retired("reset");
        release_reset("power-on");

        foreach (vecs[i]) run_vec(vecs[i]);

        run_trap("slti", 32'h0020A093);
        run_trap("slli bad funct7", 32'h40109093);

        // Reset asserted in the middle of a load's memory wait
        begin
            int n = 0;
            logic stray = 1'b0;
            wait_fetch("midmem");
            instr = 32'h0000A283;
            instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            mem_ready = 1'b0;
            #1;
            while (!MemRead && n < 10) begin @(negedge clk); #1; n++; end
            chk("midmem reached MEM", {31'd0, MemRead}, 32'd1);
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("midmem outputs cleared", misc_outs(), 32'd0);
            chk("midmem pc_sel", {30'd0, pc_sel}, {30'd0, RST_SEL});
            chk("midmem ir", ir, 32'd0);
            exp_retired = 0;
            chk_retired("midmem");
            mem_ready = 1'b1;
            repeat (2) begin
                @(posedge clk); #1;
                if (pc_we || RegWrite) stray = 1'b1;
            end
            mem_ready = 1'b0;
            chk("midmem no pulses in reset", {31'd0, stray}, 32'd0);
            $display("txn midmem reset: outputs=%0h stray=%b", misc_outs(), stray);
            release_reset("midmem");
        end

        // Recovery after reset
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that drives the ALU's control interface. It fetches a 32-bit RV32I instruction over a valid/ready handshake and decodes it into the ALU's one-hot branch flags and `ALUop`/`ALUSrc`/`sftmd` codes. It then sequences execute, memory and writeback, using the ALU's `branch_result` to steer the PC. It sits between instruction memory and the datapath (ALU, register file, data memory, PC register).

## Interface
Parameters:
- `RESET_PC_SEL`, default 2'd0: `pc_sel` value driven while idle.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `instr_valid`  in  1  instruction memory has a word
- `instr`  in  32  instruction word
- `instr_ready`  out  1  controller accepts `instr` this cycle
- `mem_ready`  in  1  data memory completes the current access
- `branch_result`  in  1  ALU branch outcome
- `ALUop`  out  4  ALU operation code
- `ALUSrc`  out  1  select `imm32` as operand 2
- `sftmd`  out  1  shift-class operation
- `Branch`, `nBranch`, `Branch_lt`, `Branch_ge`, `Branch_ltu`, `Branch_geu`  out  1 each  one-hot branch type
- `MemRead`, `MemWrite`  out  1 each  data memory strobes, held until `mem_ready`
- `RegWrite`  out  1  one-cycle register-file write pulse
- `wb_sel`  out  2  writeback source: 0 ALU, 1 memory, 2 pc+4
- `pc_we`  out  1  one-cycle PC update pulse
- `pc_sel`  out  2  next PC: 0 pc+4, 1 pc+imm, 2 `Alu_result` with bit 0 cleared
- `ir`  out  32  latched instruction (feeds immediate generator and register-file addresses)
- `trap`  out  1  sticky illegal-instruction flag

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: reset state. Always moves to FETCH on the next cycle.
- FETCH: `instr_ready`=1. When `instr_valid`&&`instr_ready`, latch `ir` and go to DECODE.
- DECODE: classify `ir`.
  - Illegal instruction: go to TRAP.
  - Otherwise: register the control bundle and go to EXEC.
- R-type (0110011), decoded from funct7/funct3:
  - `ALUop`: add 0000, sub 0001, xor 0010, or 0011, and 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
  - `ALUSrc`=0. `sftmd`=1 for sll/srl/sra only.
  - Any other funct7/funct3 combination is illegal.
- I-ALU (0010011), `ALUSrc`=1:
  - `ALUop`: addi 0000, xori 0001, ori 0010, andi 0011, slli 0100, srai 0101, srli 0110. `sftmd`=1 for the three shifts.
  - slti and sltiu (funct3 010/011) are illegal.
  - Shifts with a bad funct7 are illegal.
- Load (0000011), store (0100011), jalr (1100111, funct3 000): `ALUop` 0000, `ALUSrc` 1.
- lui: `ALUop` 1000, `ALUSrc` 1. auipc: `ALUop` 1001, `ALUSrc` 1.
- Branch (1100011): `ALUop` 0000, `ALUSrc` 0, exactly one flag set by funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu. funct3 010/011 are illegal.
- jal (1101111): ALU controls are all 0.
- Every other opcode is illegal.
- EXEC, by class:
  - Branch: `pc_sel`=`branch_result`?1:0, pulse `pc_we`, go to FETCH.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM:
  - Hold `MemRead` (load) or `MemWrite` (store) until `mem_ready`.
  - Load: on `mem_ready`, go to WB.
  - Store: on `mem_ready`, pulse `pc_we` with `pc_sel`=0 and go to FETCH.
- WB: pulse `RegWrite`, then go to FETCH.
  - `wb_sel`: 1 for load, 2 for jal/jalr, otherwise 0.
  - `pc_we`=1. `pc_sel`: 1 for jal, 2 for jalr, otherwise 0.
- TRAP: `trap`=1 and all other outputs 0. Only `rst_n` exits TRAP.

## Timing
- Reset values: every output 0; `pc_sel`=`RESET_PC_SEL`; `ir`=0; state IDLE.
- Reset is asynchronous at any point, including mid-MEM:
  - Outputs clear immediately.
  - No `pc_we` or `RegWrite` is issued.
  - First FETCH is the second cycle after `rst_n` rises.
- ALU control outputs are registered. They change only on the DECODE→EXEC edge and are held through EXEC, MEM and WB.
- `branch_result` is sampled in EXEC only.
- Cycles from the handshake cycle to the `pc_we` pulse, inclusive:

  | Class | Cycles |
  |---|---|
  | Branch | 3 |
  | ALU, lui, auipc, jal, jalr | 4 |
  | Store | 4 + memory wait |
  | Load | 5 + memory wait |

- `mem_ready` already high in the first MEM cycle completes the access in that cycle (zero wait).
- `instr_valid` outside FETCH is ignored. `instr_ready` is never 1 outside FETCH.
- `RegWrite` and `pc_we` are each high for exactly one cycle per instruction and are never both driven from different instructions.

## Configuration
- Macro `CTRL_RETIRE_CNT_EN`.
- Defined:
  - Adds output `retired_cnt` [31:0]. It increments by 1 on every `pc_we` pulse and wraps from 0xFFFFFFFF to 0.
  - Reset value 0. Trapped instructions are not counted.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `ctrl_pkg`:
  - opcode constants;
  - `ALUop` code constants (separate R and I tables, as listed above);
  - state enum;
  - `wb_sel`/`pc_sel` encodings.
- Sub-module `ctrl_decode`: combinational map from `ir` to the control bundle plus an `illegal` flag, instantiated once and registered in DECODE.

## Test plan
- add x3,x1,x2 (0x002081B3):
  - DECODE→EXEC gives `ALUop`=0000, `ALUSrc`=0, `sftmd`=0.
  - `RegWrite`, `pc_we`, `wb_sel`=0 and `pc_sel`=0 appear on handshake+3.
- srai x1,x1,3 (0x4030D093): `ALUop`=0101, `ALUSrc`=1, `sftmd`=1; one `RegWrite` pulse.
- lw x5,0(x1) (0x0000A283) with `mem_ready` asserted on the 4th MEM cycle:
  - `MemRead` is high for 4 cycles.
  - Next cycle: `RegWrite`=1 with `wb_sel`=1.
- beq x1,x2,8 (0x00208463):
  - `branch_result`=1: `Branch`=1, other flags 0, `pc_sel`=1 with `pc_we` in EXEC, no `RegWrite`.
  - Repeat with `branch_result`=0: `pc_sel`=0.
- slti (0x0020A093):
  - `trap`=1 after DECODE; `pc_we` never pulses.
  - `instr_ready` stays 0 until `rst_n`; `retired_cnt` (when enabled) is unchanged.
- Reset asserted in MEM: all outputs 0 in the same cycle; IDLE then FETCH after release; `retired_cnt`=0.
